// File: rtl/iddmm_col_acc_128.sv
// Column accumulator behind the IDDMM 128x128 multiplier: sums each column's products, emits one
// K-bit word per column end, then flushes two high words. Optional macro: IDDMM_COL_ACC_OVF_CHECK_EN.
module iddmm_col_acc_128 #(
   parameter int unsigned K     = 128,
   parameter int unsigned GUARD = 8
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   input  logic           i_in_valid,
   output logic           o_in_ready,
   input  logic [2*K-1:0] i_in_prod,
   input  logic           i_in_col_end,
   input  logic           i_in_last,
   output logic           o_out_valid,
   input  logic           i_out_ready,
   output logic [K-1:0]   o_out_word,
   output logic           o_out_last,
   output logic           o_done,
   output logic           o_ovf
);

   localparam int unsigned AW = 2 * K + GUARD;

   typedef enum logic [1:0] {StIdle, StAcc, StFlush} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [AW-1:0]  r_acc;
   logic [K-1:0]   r_out_word;
   logic           r_out_valid;
   logic           r_out_last;
   logic           r_done;
   logic [1:0]     r_flush_cnt;

   logic           w_out_free;
   logic           w_out_hs;
   logic           w_accept;
   logic           w_col_end;
   logic           w_flush_emit;
   logic           w_clear;
   logic           w_ovf;
   logic [AW-1:0]  w_sum;

   assign w_out_free   = !r_out_valid || i_out_ready;
   assign w_out_hs     = r_out_valid && i_out_ready;
   assign w_accept     = i_in_valid && o_in_ready;
   // A stray in_last closes its column so the result stays consistent.
   assign w_col_end    = i_in_col_end || i_in_last;
   assign w_flush_emit = (r_state == StFlush) && w_out_free && (r_flush_cnt != 2'd2);
   assign w_clear      = (r_state == StIdle) && i_start;
   assign w_sum        = r_acc + AW'(i_in_prod);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_nxt = StAcc;
         StAcc:   if (w_accept && i_in_last) w_state_nxt = StFlush;
         StFlush: if (w_out_hs && r_out_last) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      o_in_ready  = (r_state == StAcc) && w_out_free;
      o_out_valid = r_out_valid;
      o_out_word  = r_out_word;
      o_out_last  = r_out_last;
      o_done      = r_done;
      o_ovf       = w_ovf;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc       <= '0;
         r_flush_cnt <= '0;
         r_out_word  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_clear) begin
            r_acc       <= '0;
            r_flush_cnt <= '0;
         end else if (w_accept) begin
            r_acc <= w_col_end ? (w_sum >> K) : w_sum;
         end else if (w_flush_emit) begin
            r_acc       <= r_acc >> K;
            r_flush_cnt <= r_flush_cnt + 2'd1;
         end

         // Single-entry output register; reload may coincide with drain.
         if (w_accept && w_col_end) begin
            r_out_word  <= w_sum[K-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
         end else if (w_flush_emit) begin
            r_out_word  <= r_acc[K-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= (r_flush_cnt == 2'd1);
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end

         r_done <= w_out_hs && r_out_last;
      end
   end

`ifdef IDDMM_COL_ACC_OVF_CHECK_EN
   logic [GUARD:0] r_col_cnt;
   logic           r_ovf;

   // Top counter bit set means 2**GUARD products already sit in this column.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_col_cnt <= '0;
         r_ovf     <= 1'b0;
      end else if (w_clear) begin
         r_col_cnt <= '0;
         r_ovf     <= 1'b0;
      end else if (w_accept) begin
         if (r_col_cnt[GUARD]) r_ovf <= 1'b1;
         if (w_col_end) begin
            r_col_cnt <= '0;
         end else if (!(&r_col_cnt)) begin
            r_col_cnt <= r_col_cnt + (GUARD + 1)'(1);
         end
      end
   end

   assign w_ovf = r_ovf;
`else
   assign w_ovf = 1'b0;
`endif

endmodule
